// File: rtl/tcp_tx_active_open_ctrl.sv
// Active-open controller: allocates a flow ID, initialises per-flow state, sends SYN with
// bounded retransmission, completes with ACK and reports the outcome to the application.
module tcp_tx_active_open_ctrl #(
  parameter int FLOWID_W       = 6,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                app_open_req_val,
  output logic                app_open_req_rdy,
  input  logic [31:0]         app_open_req_dst_ip,
  input  logic [15:0]         app_open_req_dst_port,
  input  logic [15:0]         app_open_req_src_port,
  output logic                flowid_manager_req,
  input  logic                flowid_avail,
  input  logic [FLOWID_W-1:0] flowid_manager_flowid,
  output logic                flowid_free_val,
  input  logic                flowid_free_rdy,
  output logic                init_state_val,
  input  logic                init_state_rdy,
  output logic                send_pkt_enqueue_val,
  input  logic                send_pkt_enqueue_rdy,
  output logic [7:0]          send_pkt_flags,
  input  logic                synack_val,
  input  logic [FLOWID_W-1:0] synack_flowid,
  output logic                synack_rdy,
  output logic                app_open_resp_val,
  input  logic                app_open_resp_rdy,
  output logic                app_open_resp_ok,
  output logic [FLOWID_W-1:0] conn_flowid,
  output logic [31:0]         conn_dst_ip,
  output logic [15:0]         conn_dst_port,
  output logic [15:0]         conn_src_port
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [7:0]    FLAG_SYN   = 8'h02;
  localparam logic [7:0]    FLAG_ACK   = 8'h10;

  typedef enum logic [2:0] {
    IDLE, GET_FLOWID, INIT_STATE, SEND_SYN, WAIT_SYNACK, SEND_ACK, FREE_FLOWID, NOTIF_APP
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [RW-1:0] retry_cnt_reg;
  logic          ok_reg;
  logic          synack_match;

  // Both ready outputs are pure decodes of the state register.
  assign app_open_req_rdy = (state_reg == IDLE);
  assign synack_rdy       = (state_reg == WAIT_SYNACK);
  assign synack_match     = synack_val && (synack_flowid == conn_flowid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      timer_reg            <= '0;
      retry_cnt_reg        <= '0;
      ok_reg               <= 1'b0;
      conn_flowid          <= '0;
      conn_dst_ip          <= '0;
      conn_dst_port        <= '0;
      conn_src_port        <= '0;
      flowid_manager_req   <= 1'b0;
      init_state_val       <= 1'b0;
      send_pkt_enqueue_val <= 1'b0;
      send_pkt_flags       <= '0;
      flowid_free_val      <= 1'b0;
      app_open_resp_val    <= 1'b0;
      app_open_resp_ok     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (app_open_req_val) begin
            conn_dst_ip        <= app_open_req_dst_ip;
            conn_dst_port      <= app_open_req_dst_port;
            conn_src_port      <= app_open_req_src_port;
            retry_cnt_reg      <= '0;
            ok_reg             <= 1'b0;
            flowid_manager_req <= 1'b1;
            state_reg          <= GET_FLOWID;
          end
        end
        GET_FLOWID: begin
          flowid_manager_req <= 1'b0;
          if (flowid_avail) begin
            conn_flowid    <= flowid_manager_flowid;
            init_state_val <= 1'b1;
            state_reg      <= INIT_STATE;
          end else begin
            ok_reg            <= 1'b0;
            app_open_resp_val <= 1'b1;
            app_open_resp_ok  <= 1'b0;
            state_reg         <= NOTIF_APP;
          end
        end
        INIT_STATE: begin
          if (init_state_rdy) begin
            init_state_val       <= 1'b0;
            send_pkt_enqueue_val <= 1'b1;
            send_pkt_flags       <= FLAG_SYN;
            state_reg            <= SEND_SYN;
          end
        end
        SEND_SYN: begin
          if (send_pkt_enqueue_rdy) begin
            send_pkt_enqueue_val <= 1'b0;
            send_pkt_flags       <= '0;
            timer_reg            <= '0;
            state_reg            <= WAIT_SYNACK;
          end
        end
        WAIT_SYNACK: begin
          timer_reg <= timer_reg + TW'(1);
          // A matching SYN-ACK takes priority over an expiring timer.
          if (synack_match) begin
            send_pkt_enqueue_val <= 1'b1;
            send_pkt_flags       <= FLAG_ACK;
            state_reg            <= SEND_ACK;
          end else if (timer_reg == TIMER_LAST) begin
            if (retry_cnt_reg < RETRY_MAX) begin
              retry_cnt_reg        <= retry_cnt_reg + RW'(1);
              send_pkt_enqueue_val <= 1'b1;
              send_pkt_flags       <= FLAG_SYN;
              state_reg            <= SEND_SYN;
            end else begin
              ok_reg          <= 1'b0;
              flowid_free_val <= 1'b1;
              state_reg       <= FREE_FLOWID;
            end
          end
        end
        SEND_ACK: begin
          if (send_pkt_enqueue_rdy) begin
            send_pkt_enqueue_val <= 1'b0;
            send_pkt_flags       <= '0;
            ok_reg               <= 1'b1;
            app_open_resp_val    <= 1'b1;
            app_open_resp_ok     <= 1'b1;
            state_reg            <= NOTIF_APP;
          end
        end
        FREE_FLOWID: begin
          if (flowid_free_rdy) begin
            flowid_free_val   <= 1'b0;
            app_open_resp_val <= 1'b1;
            app_open_resp_ok  <= ok_reg;
            state_reg         <= NOTIF_APP;
          end
        end
        NOTIF_APP: begin
          if (app_open_resp_rdy) begin
            app_open_resp_val <= 1'b0;
            app_open_resp_ok  <= 1'b0;
            state_reg         <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_active_open_ctrl.sv
// Directed bench for tcp_tx_active_open_ctrl: one task per scenario, inputs driven on the
// falling edge, handshakes observed by a rising-edge monitor.
module tb_tcp_tx_active_open_ctrl;
  localparam int FW = 6;
  localparam int TO = 16;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          app_open_req_val, app_open_req_rdy;
  logic [31:0]   app_open_req_dst_ip;
  logic [15:0]   app_open_req_dst_port, app_open_req_src_port;
  logic          flowid_manager_req, flowid_avail;
  logic [FW-1:0] flowid_manager_flowid;
  logic          flowid_free_val, flowid_free_rdy;
  logic          init_state_val, init_state_rdy;
  logic          send_pkt_enqueue_val, send_pkt_enqueue_rdy;
  logic [7:0]    send_pkt_flags;
  logic          synack_val, synack_rdy;
  logic [FW-1:0] synack_flowid;
  logic          app_open_resp_val, app_open_resp_rdy, app_open_resp_ok;
  logic [FW-1:0] conn_flowid;
  logic [31:0]   conn_dst_ip;
  logic [15:0]   conn_dst_port, conn_src_port;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcp_tx_active_open_ctrl #(.FLOWID_W(FW), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst_n(rst_n),
    .app_open_req_val(app_open_req_val), .app_open_req_rdy(app_open_req_rdy),
    .app_open_req_dst_ip(app_open_req_dst_ip), .app_open_req_dst_port(app_open_req_dst_port),
    .app_open_req_src_port(app_open_req_src_port),
    .flowid_manager_req(flowid_manager_req), .flowid_avail(flowid_avail),
    .flowid_manager_flowid(flowid_manager_flowid),
    .flowid_free_val(flowid_free_val), .flowid_free_rdy(flowid_free_rdy),
    .init_state_val(init_state_val), .init_state_rdy(init_state_rdy),
    .send_pkt_enqueue_val(send_pkt_enqueue_val), .send_pkt_enqueue_rdy(send_pkt_enqueue_rdy),
    .send_pkt_flags(send_pkt_flags),
    .synack_val(synack_val), .synack_flowid(synack_flowid), .synack_rdy(synack_rdy),
    .app_open_resp_val(app_open_resp_val), .app_open_resp_rdy(app_open_resp_rdy),
    .app_open_resp_ok(app_open_resp_ok),
    .conn_flowid(conn_flowid), .conn_dst_ip(conn_dst_ip), .conn_dst_port(conn_dst_port),
    .conn_src_port(conn_src_port)
  );

  // Handshake monitor
  int            cyc = 0;
  int            req_cnt = 0, init_cnt = 0, syn_cnt = 0, ack_cnt = 0, free_cnt = 0, resp_cnt = 0;
  int            bad_flag_cnt = 0;
  int            syn_cyc [64];
  int            free_cyc = 0, resp_cyc = 0;
  logic          resp_ok_seen = 1'b0;
  logic [FW-1:0] resp_flowid = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (flowid_manager_req) req_cnt <= req_cnt + 1;
      if (init_state_val && init_state_rdy) init_cnt <= init_cnt + 1;
      if (send_pkt_enqueue_val && send_pkt_enqueue_rdy) begin
        if (send_pkt_flags == 8'h02) begin
          syn_cyc[syn_cnt % 64] <= cyc;
          syn_cnt <= syn_cnt + 1;
        end else if (send_pkt_flags == 8'h10) ack_cnt <= ack_cnt + 1;
        else bad_flag_cnt <= bad_flag_cnt + 1;
      end
      if (!send_pkt_enqueue_val && send_pkt_flags != 8'h00) bad_flag_cnt <= bad_flag_cnt + 1;
      if (flowid_free_val && flowid_free_rdy) begin
        free_cnt <= free_cnt + 1;
        free_cyc <= cyc;
      end
      if (app_open_resp_val && app_open_resp_rdy) begin
        resp_cnt     <= resp_cnt + 1;
        resp_cyc     <= cyc;
        resp_ok_seen <= app_open_resp_ok;
        resp_flowid  <= conn_flowid;
      end
    end
  end

  task automatic do_open(input logic [31:0] ip, input logic [15:0] dp, input logic [15:0] sp,
                         output bit to);
    @(negedge clk);
    app_open_req_val = 1'b1;
    app_open_req_dst_ip = ip;
    app_open_req_dst_port = dp;
    app_open_req_src_port = sp;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (app_open_req_rdy) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    app_open_req_val = 1'b0;
  endtask

  task automatic wait_synack_rdy(output bit to);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (synack_rdy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int base, output bit to);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_cnt > base) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_synack(input logic [FW-1:0] f);
    synack_val = 1'b1;
    synack_flowid = f;
    @(negedge clk);
    synack_val = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (app_open_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy: got %b, expected 1", app_open_req_rdy); end
    checks++; if ({flowid_manager_req, init_state_val, send_pkt_enqueue_val, flowid_free_val, app_open_resp_val, synack_rdy} !== 6'b0) begin
      errors++; $display("FAIL reset_vals: got %b, expected 000000", {flowid_manager_req, init_state_val, send_pkt_enqueue_val, flowid_free_val, app_open_resp_val, synack_rdy}); end
    checks++; if (send_pkt_flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h, expected 00", send_pkt_flags); end
    checks++; if ({conn_flowid, conn_dst_ip, conn_dst_port, conn_src_port} !== '0) begin errors++; $display("FAIL reset_conn: got %h/%h, expected 0/0", conn_flowid, conn_dst_ip); end
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_open_ok();
    int b_syn = syn_cnt, b_ack = ack_cnt, b_free = free_cnt, b_resp = resp_cnt;
    bit to;
    flowid_avail = 1'b1;
    flowid_manager_flowid = 6'd5;
    do_open(32'h0A000002, 16'd80, 16'd1234, to);
    checks++; if (to) begin errors++; $display("FAIL ok_open_hs: got timeout, expected handshake"); end
    wait_synack_rdy(to);
    checks++; if (to) begin errors++; $display("FAIL ok_wait_synack: got timeout, expected synack_rdy"); end
    checks++; if (conn_flowid !== 6'd5) begin errors++; $display("FAIL ok_conn_flowid: got %0d, expected 5", conn_flowid); end
    checks++; if (conn_dst_ip !== 32'h0A000002) begin errors++; $display("FAIL ok_conn_ip: got %h, expected 0a000002", conn_dst_ip); end
    checks++; if ({conn_dst_port, conn_src_port} !== {16'd80, 16'd1234}) begin errors++; $display("FAIL ok_conn_ports: got %0d/%0d, expected 80/1234", conn_dst_port, conn_src_port); end
    repeat (9) @(negedge clk);
    send_synack(6'd5);
    wait_resp(b_resp, to);
    checks++; if (to) begin errors++; $display("FAIL ok_resp: got timeout, expected response"); end
    checks++; if (syn_cnt - b_syn != 1) begin errors++; $display("FAIL ok_syn_count: got %0d, expected 1", syn_cnt - b_syn); end
    checks++; if (ack_cnt - b_ack != 1) begin errors++; $display("FAIL ok_ack_count: got %0d, expected 1", ack_cnt - b_ack); end
    checks++; if (free_cnt != b_free) begin errors++; $display("FAIL ok_free_count: got %0d, expected 0", free_cnt - b_free); end
    checks++; if (resp_ok_seen !== 1'b1) begin errors++; $display("FAIL ok_resp_ok: got %b, expected 1", resp_ok_seen); end
    checks++; if (resp_flowid !== 6'd5) begin errors++; $display("FAIL ok_resp_flowid: got %0d, expected 5", resp_flowid); end
    checks++; if (app_open_req_rdy !== 1'b1) begin errors++; $display("FAIL ok_back_idle: got %b, expected 1", app_open_req_rdy); end
    $display("open ok: flowid=%0d resp_ok=%0b syn=%0d ack=%0d", resp_flowid, resp_ok_seen, syn_cnt - b_syn, ack_cnt - b_ack);
  endtask

  task automatic test_no_flowid();
    int b_req = req_cnt, b_init = init_cnt, b_syn = syn_cnt, b_free = free_cnt, b_resp = resp_cnt;
    int lat = 99;
    bit to;
    flowid_avail = 1'b0;
    app_open_resp_rdy = 1'b0;
    do_open(32'hC0A80001, 16'd443, 16'd5000, to);
    for (int i = 1; i <= 5; i++) begin
      if (app_open_resp_val) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    // Request accepted one edge before do_open returns, so lat counts from that edge.
    checks++; if (lat > 3) begin errors++; $display("FAIL nofid_latency: got %0d, expected <=3", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({app_open_resp_val, app_open_resp_ok} !== 2'b10) begin errors++; $display("FAIL nofid_stall_resp: got %b, expected 10", {app_open_resp_val, app_open_resp_ok}); end
      @(negedge clk);
    end
    app_open_resp_rdy = 1'b1;
    wait_resp(b_resp, to);
    checks++; if (to) begin errors++; $display("FAIL nofid_resp: got timeout, expected response"); end
    checks++; if (resp_ok_seen !== 1'b0) begin errors++; $display("FAIL nofid_resp_ok: got %b, expected 0", resp_ok_seen); end
    checks++; if (req_cnt - b_req != 1) begin errors++; $display("FAIL nofid_req_cycles: got %0d, expected 1", req_cnt - b_req); end
    checks++; if ((init_cnt - b_init) + (syn_cnt - b_syn) + (free_cnt - b_free) != 0) begin errors++; $display("FAIL nofid_side_effects: got %0d, expected 0", (init_cnt - b_init) + (syn_cnt - b_syn) + (free_cnt - b_free)); end
    $display("open no-flowid: resp_ok=%0b latency=%0d", resp_ok_seen, lat);
    flowid_avail = 1'b1;
  endtask

  task automatic test_timeout();
    int b_syn = syn_cnt, b_ack = ack_cnt, b_free = free_cnt, b_resp = resp_cnt;
    bit to;
    flowid_manager_flowid = 6'd5;
    flowid_free_rdy = 1'b0;
    do_open(32'h0A000003, 16'd22, 16'd4000, to);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flowid_free_val) begin
        to = 1'b0;
        break;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL to_free_val: got timeout, expected flowid_free_val"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({flowid_free_val, app_open_resp_val, conn_flowid} !== {2'b10, 6'd5}) begin errors++; $display("FAIL to_free_stall: got %b/%0d, expected 10/5", {flowid_free_val, app_open_resp_val}, conn_flowid); end
    end
    flowid_free_rdy = 1'b1;
    wait_resp(b_resp, to);
    checks++; if (to) begin errors++; $display("FAIL to_resp: got timeout, expected response"); end
    checks++; if (syn_cnt - b_syn != MR + 1) begin errors++; $display("FAIL to_syn_count: got %0d, expected %0d", syn_cnt - b_syn, MR + 1); end
    // Each retransmit follows TO waiting cycles plus the one-cycle SYN handshake.
    for (int i = 0; i < MR; i++) begin
      checks++; if (syn_cyc[(b_syn + i + 1) % 64] - syn_cyc[(b_syn + i) % 64] != TO + 1) begin errors++; $display("FAIL to_syn_gap%0d: got %0d, expected %0d", i, syn_cyc[(b_syn + i + 1) % 64] - syn_cyc[(b_syn + i) % 64], TO + 1); end
    end
    checks++; if (free_cnt - b_free != 1) begin errors++; $display("FAIL to_free_count: got %0d, expected 1", free_cnt - b_free); end
    checks++; if (free_cyc >= resp_cyc) begin errors++; $display("FAIL to_free_order: got free@%0d resp@%0d, expected free first", free_cyc, resp_cyc); end
    checks++; if (resp_ok_seen !== 1'b0 || ack_cnt != b_ack) begin errors++; $display("FAIL to_result: got ok=%b acks=%0d, expected ok=0 acks=0", resp_ok_seen, ack_cnt - b_ack); end
    $display("open timeout: syns=%0d freed=%0d resp_ok=%0b", syn_cnt - b_syn, free_cnt - b_free, resp_ok_seen);
  endtask

  task automatic test_wrong_flowid();
    int b_syn = syn_cnt, b_ack = ack_cnt, b_free = free_cnt, b_resp = resp_cnt;
    bit to;
    flowid_manager_flowid = 6'd5;
    do_open(32'h0A000004, 16'd8080, 16'd4001, to);
    wait_synack_rdy(to);
    checks++; if (to) begin errors++; $display("FAIL wf_wait_synack: got timeout, expected synack_rdy"); end
    repeat (7) @(negedge clk);
    send_synack(6'd7);
    checks++; if (synack_rdy !== 1'b1 || ack_cnt != b_ack) begin errors++; $display("FAIL wf_discard: got rdy=%b acks=%0d, expected rdy=1 acks=0", synack_rdy, ack_cnt - b_ack); end
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (syn_cnt - b_syn >= 2) begin
        to = 1'b0;
        break;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL wf_retx: got timeout, expected second SYN"); end
    checks++; if (syn_cyc[(b_syn + 1) % 64] - syn_cyc[b_syn % 64] != TO + 1) begin errors++; $display("FAIL wf_timer_kept: got gap %0d, expected %0d", syn_cyc[(b_syn + 1) % 64] - syn_cyc[b_syn % 64], TO + 1); end
    wait_synack_rdy(to);
    repeat (3) @(negedge clk);
    send_synack(6'd5);
    wait_resp(b_resp, to);
    checks++; if (to) begin errors++; $display("FAIL wf_resp: got timeout, expected response"); end
    checks++; if (resp_ok_seen !== 1'b1 || ack_cnt - b_ack != 1 || free_cnt != b_free) begin errors++; $display("FAIL wf_result: got ok=%b acks=%0d frees=%0d, expected 1/1/0", resp_ok_seen, ack_cnt - b_ack, free_cnt - b_free); end
    $display("open wrong-flowid: syns=%0d resp_ok=%0b", syn_cnt - b_syn, resp_ok_seen);
  endtask

  task automatic test_match_on_timeout();
    int b_syn = syn_cnt, b_ack = ack_cnt, b_free = free_cnt, b_resp = resp_cnt;
    bit to;
    flowid_manager_flowid = 6'd5;
    do_open(32'h0A000005, 16'd25, 16'd4002, to);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (syn_cnt - b_syn >= MR + 1) begin
        to = 1'b0;
        break;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL mt_last_syn: got timeout, expected last SYN"); end
    // Land the SYN-ACK on the edge that samples timer == TO-1.
    repeat (TO - 1) @(negedge clk);
    checks++; if (synack_rdy !== 1'b1) begin errors++; $display("FAIL mt_still_waiting: got %b, expected 1", synack_rdy); end
    send_synack(6'd5);
    wait_resp(b_resp, to);
    checks++; if (to) begin errors++; $display("FAIL mt_resp: got timeout, expected response"); end
    checks++; if (ack_cnt - b_ack != 1) begin errors++; $display("FAIL mt_ack: got %0d, expected 1", ack_cnt - b_ack); end
    checks++; if (free_cnt != b_free) begin errors++; $display("FAIL mt_no_free: got %0d, expected 0", free_cnt - b_free); end
    checks++; if (resp_ok_seen !== 1'b1) begin errors++; $display("FAIL mt_resp_ok: got %b, expected 1", resp_ok_seen); end
    $display("open match-on-timeout: syns=%0d ack=%0d resp_ok=%0b", syn_cnt - b_syn, ack_cnt - b_ack, resp_ok_seen);
  endtask

  task automatic test_stall_reset();
    int b_free, b_resp;
    bit to;
    flowid_manager_flowid = 6'd9;
    init_state_rdy = 1'b0;
    send_pkt_enqueue_rdy = 1'b0;
    do_open(32'h0A000006, 16'd21, 16'd4003, to);
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (init_state_val) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++; if (to) begin errors++; $display("FAIL sr_init_val: got timeout, expected init_state_val"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({init_state_val, conn_flowid} !== {1'b1, 6'd9}) begin errors++; $display("FAIL sr_init_stall: got %b/%0d, expected 1/9", init_state_val, conn_flowid); end
    end
    init_state_rdy = 1'b1;
    @(negedge clk);
    init_state_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({send_pkt_enqueue_val, send_pkt_flags} !== {1'b1, 8'h02}) begin errors++; $display("FAIL sr_syn_stall: got %b/%h, expected 1/02", send_pkt_enqueue_val, send_pkt_flags); end
      @(negedge clk);
    end
    send_pkt_enqueue_rdy = 1'b1;
    @(negedge clk);
    checks++; if (synack_rdy !== 1'b1) begin errors++; $display("FAIL sr_in_wait: got %b, expected 1", synack_rdy); end
    repeat (3) @(negedge clk);
    b_free = free_cnt;
    b_resp = resp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    init_state_rdy = 1'b1;
    checks++; if ({app_open_req_rdy, synack_rdy} !== 2'b10) begin errors++; $display("FAIL sr_idle: got %b, expected 10", {app_open_req_rdy, synack_rdy}); end
    checks++; if ({flowid_manager_req, init_state_val, send_pkt_enqueue_val, flowid_free_val, app_open_resp_val, send_pkt_flags} !== '0) begin errors++; $display("FAIL sr_outputs: got %b/%h, expected 0/00", {flowid_manager_req, init_state_val, send_pkt_enqueue_val, flowid_free_val, app_open_resp_val}, send_pkt_flags); end
    checks++; if ({conn_flowid, conn_dst_ip} !== '0) begin errors++; $display("FAIL sr_conn: got %0d/%h, expected 0/0", conn_flowid, conn_dst_ip); end
    repeat (20) @(negedge clk);
    checks++; if (free_cnt != b_free || resp_cnt != b_resp) begin errors++; $display("FAIL sr_aborted: got frees=%0d resps=%0d, expected 0/0", free_cnt - b_free, resp_cnt - b_resp); end
    $display("open aborted by reset: app_open_req_rdy=%0b", app_open_req_rdy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    app_open_req_val = 1'b0;
    app_open_req_dst_ip = '0;
    app_open_req_dst_port = '0;
    app_open_req_src_port = '0;
    flowid_avail = 1'b1;
    flowid_manager_flowid = '0;
    flowid_free_rdy = 1'b1;
    init_state_rdy = 1'b1;
    send_pkt_enqueue_rdy = 1'b1;
    synack_val = 1'b0;
    synack_flowid = '0;
    app_open_resp_rdy = 1'b1;
    test_reset();
    test_open_ok();
    test_no_flowid();
    test_timeout();
    test_wrong_flowid();
    test_match_on_timeout();
    test_stall_reset();
    checks++; if (bad_flag_cnt != 0) begin errors++; $display("FAIL flags_protocol: got %0d bad cycles, expected 0", bad_flag_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
